reg_wr_arbiter: RTL
===================

Name: reg_wr_arbiter

Overview:
Shares a bank of N_REG 1-bit enable registers (clk_i/nrst_i/en_i/d_i/q_o cells) between N_REQ requesters.
- Each requester asks to write one bit to one register address.
- The block picks a requester round-robin and drives the one-hot per-cell write enables and the shared data bit.
- It sits between the control agents and the register bank. It is the only driver of the bank's en_i/d_i nets.

Parameters:
N_REQ, 4, number of requesters (2..16)
N_REG, 8, number of 1-bit registers in the bank (2..64)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= N_REG

Ports:
clk_i  input  1  clock; all state updates on rising edge
nrst_i  input  1  asynchronous active-low reset
req_i  input  N_REQ  per-requester write request; level, held until granted
addr_i  input  N_REQ*ADDR_W  packed target addresses; requester k uses bits [k*ADDR_W +: ADDR_W]
data_i  input  N_REQ  per-requester write data bit
gnt_o  output  N_REQ  one-hot grant pulse, one cycle wide
en_o  output  N_REG  one-hot write enables to the bank cells
d_o  output  1  shared data bit to the bank cells
busy_o  output  1  high while in GRANT state

Behaviour:
- Reset (nrst_i low, async):
  - gnt_o=0, en_o=0, d_o=0, busy_o=0.
  - State=IDLE; priority pointer ptr=0, so requester 0 has highest priority.
- FSM has two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req_i==0, stay in IDLE with outputs 0.
  - Otherwise choose winner w = first set bit of req_i scanning from ptr upward and wrapping modulo N_REQ.
  - On the next edge go to GRANT and register: gnt_o=1<<w, en_o=1<<addr_w, d_o=data_i[w], busy_o=1, ptr=(w+1) mod N_REQ.
- GRANT:
  - Lasts exactly one cycle. req_i is ignored during it.
  - Next edge: back to IDLE, with gnt_o=0, en_o=0, busy_o=0. d_o holds its last value.
- Handshake:
  - The requester samples gnt_o. It must drop or change req/addr/data in the cycle after gnt_o is seen.
  - Because arbitration only happens in IDLE, a still-high req in the GRANT cycle is never granted twice.
- Latency and throughput:
  - If req sampled in IDLE at edge t, gnt_o/en_o are high during cycle t..t+1. The bank cell captures d_o at edge t+1.
  - Maximum throughput is one write per 2 cycles.
- Fairness: under continuous requests from all N_REQ, each requester is granted once every 2*N_REQ cycles.
- Out-of-range address (addr >= N_REG):
  - Grant is still issued and ptr still advances.
  - en_o stays all-zero, so no cell is written.
- Same address from several requesters: only the winner writes; the losers wait for their own grant.
- Reset asserted in GRANT: outputs clear immediately (async), so no partial write is left pending.
- At most one bit of en_o and of gnt_o is ever set.

Optional Feature:
Macro REG_WR_ADDR_CHK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - err_o pulses high alongside gnt_o when the winner's address is >= N_REG.
  - An elaboration-time check rejects 2**ADDR_W < N_REG.
- Undefined: no err_o port; out-of-range writes are silently dropped as described above.

Decomposition:
- Package reg_wr_pkg holds:
  - the FSM state typedef {ST_IDLE, ST_GRANT}
  - default parameter constants
  - a function for one-hot decode of address to N_REG
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot winner, winner index, any_req.
  - Instantiated once; the FSM, pointer and output registers stay in reg_wr_arbiter.

Test Plan:
- Reset, then hold nrst_i low with req_i=4'b1111 -> all outputs 0; after release, first gnt_o=4'b0001.
- Single request req_i=4'b0100, addr2=5, data2=1 -> one cycle later gnt_o=4'b0100, en_o=8'b0010_0000, d_o=1, busy_o=1; next cycle all clear.
- All four requesters held continuously -> grant order 0,1,2,3,0 with gnt_o high every other cycle, never back-to-back.
- Requester 3 only, then requester 1 only, with ptr=0 -> grant 3 then 1; simultaneous req 1 and 2 at ptr=2 -> 2 wins first.
- Requester 0 with addr=7 and N_REG=6 -> gnt_o=4'b0001, en_o=0; with REG_WR_ADDR_CHK_EN, err_o=1 for that cycle.
- Assert nrst_i mid-GRANT -> gnt_o/en_o drop asynchronously before the next edge; ptr returns to 0.

Source files
------------

// File: rtl/reg_wr_pkg.sv
// reg_wr_pkg: shared types and helpers for the register write arbiter.
//   - state_t      : arbiter FSM state encoding (ST_IDLE, ST_GRANT)
//   - DEF_*        : default parameter values for the arbiter
//   - addr_dec_bit : one bit of the one-hot address decode, range-checked
//                    against the bank size
package reg_wr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_N_REG  = 8;
    localparam int DEF_ADDR_W = 3;

    // Bit 'idx' of the one-hot decode of 'addr' over an n_reg-wide bank.
    // Addresses at or beyond n_reg decode to all-zero, so an out-of-range
    // write never reaches a cell.
    function automatic logic addr_dec_bit(input int unsigned addr,
                                          input int unsigned idx,
                                          input int unsigned n_reg);
        return (addr < n_reg) && (addr == idx);
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans req starting at ptr, wrapping modulo N_REQ, and reports the first
// set bit.
// Ports:
//   req     in  N_REQ  request vector
//   ptr     in  PTR_W  highest-priority requester index
//   win_oh  out N_REQ  one-hot winner (zero when no request)
//   win_idx out PTR_W  winner index (zero when no request)
//   any_req out 1      at least one request is pending
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             any_req
);

    int                 pos;
    logic [PTR_W-1:0]   cand;
    logic               found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any_req = |req;
        found   = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr + i can exceed N_REQ-1 by at most N_REQ-1, so one
            // subtraction is enough to wrap.
            pos = int'(ptr) + i;
            if (pos >= N_REQ)
                pos = pos - N_REQ;
            cand = PTR_W'(pos);
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin write arbiter in front of a bank of 1-bit
// enable registers. Each requester posts (addr, data). One winner per
// arbitration drives a one-hot cell enable and the shared data bit for
// exactly one cycle. The arbiter then idles one cycle before the next
// arbitration.
// Ports:
//   clk_i   in  1             clock, rising edge
//   nrst_i  in  1             asynchronous active-low reset
//   req_i   in  N_REQ         per-requester write request (level)
//   addr_i  in  N_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   data_i  in  N_REQ         per-requester write data
//   gnt_o   out N_REQ         one-hot grant pulse
//   en_o    out N_REG         one-hot cell write enables
//   d_o     out 1             shared data bit to the cells
//   busy_o  out 1             high while in GRANT
//   err_o   out 1             (REG_WR_ADDR_CHK_EN only) winner address out of range
// Optional feature macro: REG_WR_ADDR_CHK_EN adds err_o and an elaboration
// check that 2**ADDR_W >= N_REG.
module reg_wr_arbiter
    import reg_wr_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int N_REG  = DEF_N_REG,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ-1:0]          data_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REG-1:0]          en_o,
    output logic                      d_o,
`ifdef REG_WR_ADDR_CHK_EN
    output logic                      err_o,
`endif
    output logic                      busy_o
);

    localparam int PTR_W = $clog2(N_REQ);

`ifdef REG_WR_ADDR_CHK_EN
    if ((1 << ADDR_W) < N_REG) begin : g_addr_w_chk
        $error("reg_wr_arbiter: ADDR_W too narrow to address N_REG cells");
    end
`endif

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [N_REG-1:0]   en_nxt;
    logic               d_nxt;
    logic               busy_nxt;
    logic               err_nxt;

    logic [N_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]   win_idx;
    logic               any_req;
    logic [ADDR_W-1:0]  win_addr;
    logic [N_REG-1:0]   win_en;
    logic               win_oor;

    // Unpack the address bus so the winner can be selected by index.
    logic [ADDR_W-1:0]  addr_arr [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_addr
        assign addr_arr[k] = addr_i[k*ADDR_W +: ADDR_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req_i),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    assign win_addr = addr_arr[win_idx];
    assign win_oor  = !(int'(win_addr) < N_REG);

    always_comb begin
        win_en = '0;
        for (int r = 0; r < N_REG; r++)
            win_en[r] = addr_dec_bit(int'(win_addr), r, N_REG);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        en_nxt    = '0;
        d_nxt     = d_o;          // data bit is sticky between grants
        busy_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = win_oh;
                    en_nxt    = win_en;
                    d_nxt     = data_i[win_idx];
                    busy_nxt  = 1'b1;
                    err_nxt   = win_oor;
                    // The winner drops to lowest priority next round.
                    ptr_nxt   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_GRANT: begin
                // Requests seen here are ignored. This keeps a
                // slow-to-drop requester from being granted twice.
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gnt_o  <= '0;
            en_o   <= '0;
            d_o    <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt_o  <= gnt_nxt;
            en_o   <= en_nxt;
            d_o    <= d_nxt;
            busy_o <= busy_nxt;
        end
    end

`ifdef REG_WR_ADDR_CHK_EN
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i)
            err_o <= 1'b0;
        else
            err_o <= err_nxt;
    end
`else
    // err_nxt has no consumer without the address check port.
    logic unused_err;
    assign unused_err = err_nxt;
`endif

endmodule
